// File: rtl/dmem_arbiter.sv
//------------------------------------------------------------------------------
// Module   : dmem_arbiter
// Purpose  : Round-robin store/load arbiter and sequencer for the data-memory port.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dmem_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        st_req,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_wdata,
    input  logic [3:0]  st_be,
    output logic        st_done,
    input  logic        ld_req,
    input  logic [31:0] ld_addr,
    input  logic [3:0]  ld_be,
    output logic        ld_done,
    output logic [31:0] ld_rdata,
    output logic        mem_req,
    output logic        mem_rw_mode,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic [3:0]  mem_byte_en,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        stall_pc,
    output logic        busy,
    output logic        err_timeout
);

    localparam int   CW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic OWN_ST = 1'b0;
    localparam logic OWN_LD = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nx;
    logic   r_owner;
    logic   r_last_grant;
    logic   r_abort;
    logic   w_grant;
    logic   w_grant_ld;
    logic   w_ack_hit;
    logic   w_tmo_hit;
    logic   w_tmo_expired;

    always_comb begin
        w_state_nx = r_state;
        w_grant    = 1'b0;
        w_grant_ld = 1'b0;
        w_ack_hit  = 1'b0;
        w_tmo_hit  = 1'b0;
        case (r_state)
            IDLE: begin
                if (st_req || ld_req) begin
                    w_grant    = 1'b1;
                    // On a tie the load wins only if the store had the last grant.
                    w_grant_ld = ld_req && (!st_req || (r_last_grant == OWN_ST));
                    w_state_nx = BUSY;
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    w_ack_hit  = 1'b1;
                    w_state_nx = DONE;
                end else if (w_tmo_expired) begin
                    w_tmo_hit  = 1'b1;
                    w_state_nx = DONE;
                end
            end
            DONE:    w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    generate
        if (TIMEOUT > 0) begin : g_tmo_on
            logic [CW-1:0] r_cnt;
            // Saturates at TIMEOUT-1, where the abort fires, so it never wraps.
            always_ff @(posedge i_clk or negedge i_rst) begin
                if (!i_rst) begin
                    r_cnt <= '0;
                end else if (w_grant) begin
                    r_cnt <= '0;
                end else if ((r_state == BUSY) && !mem_ack && !w_tmo_expired) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
            assign w_tmo_expired = (r_cnt == CW'(TIMEOUT - 1));
        end else begin : g_tmo_off
            assign w_tmo_expired = 1'b0;
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state        <= IDLE;
            r_owner        <= OWN_ST;
            r_last_grant   <= OWN_LD;
            r_abort        <= 1'b0;
            mem_req        <= 1'b0;
            mem_rw_mode    <= 1'b1;
            mem_addr       <= '0;
            mem_write_data <= '0;
            mem_byte_en    <= '0;
            ld_rdata       <= '0;
        end else begin
            r_state <= w_state_nx;
            if (w_grant) begin
                mem_req      <= 1'b1;
                r_owner      <= w_grant_ld;
                r_last_grant <= w_grant_ld;
                r_abort      <= 1'b0;
                if (w_grant_ld) begin
                    mem_rw_mode    <= 1'b1;
                    mem_addr       <= ld_addr;
                    mem_write_data <= '0;
                    mem_byte_en    <= ld_be;
                end else begin
                    mem_rw_mode    <= 1'b0;
                    mem_addr       <= st_addr;
                    mem_write_data <= st_wdata;
                    mem_byte_en    <= st_be;
                end
            end else if (w_ack_hit || w_tmo_hit) begin
                mem_req        <= 1'b0;
                mem_rw_mode    <= 1'b1;
                mem_addr       <= '0;
                mem_write_data <= '0;
                mem_byte_en    <= '0;
                r_abort        <= w_tmo_hit;
                if (r_owner == OWN_LD) begin
                    ld_rdata <= w_ack_hit ? mem_rdata : '0;
                end
            end
        end
    end

    assign busy        = (r_state != IDLE);
    assign stall_pc    = st_req || ld_req || (r_state != IDLE);
    assign st_done     = (r_state == DONE) && (r_owner == OWN_ST);
    assign ld_done     = (r_state == DONE) && (r_owner == OWN_LD);
    assign err_timeout = (r_state == DONE) && r_abort;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_dmem_arbiter
// Purpose  : Directed self-checking bench for dmem_arbiter (TIMEOUT = 4).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        st_req, ld_req, mem_ack;
    logic [31:0] st_addr, st_wdata, ld_addr, mem_rdata;
    logic [3:0]  st_be, ld_be;
    logic        st_done, ld_done, mem_req, mem_rw_mode, stall_pc, busy, err_timeout;
    logic [31:0] ld_rdata, mem_addr, mem_write_data;
    logic [3:0]  mem_byte_en;

    int checks = 0;
    int errors = 0;

    dmem_arbiter #(.TIMEOUT(4)) dut (
        .i_clk(clk), .i_rst(rst_n),
        .st_req(st_req), .st_addr(st_addr), .st_wdata(st_wdata), .st_be(st_be), .st_done(st_done),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_be(ld_be), .ld_done(ld_done), .ld_rdata(ld_rdata),
        .mem_req(mem_req), .mem_rw_mode(mem_rw_mode), .mem_addr(mem_addr),
        .mem_write_data(mem_write_data), .mem_byte_en(mem_byte_en),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .stall_pc(stall_pc), .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    wire [69:0] port_vec = {mem_req, mem_rw_mode, mem_addr, mem_write_data, mem_byte_en};
    wire [2:0]  done_vec = {st_done, ld_done, err_timeout};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; st_req = 0; ld_req = 0; mem_ack = 0;
        st_addr = 0; st_wdata = 0; st_be = 0; ld_addr = 0; ld_be = 0; mem_rdata = 0;
        tick(); tick();
        checks++;
        if (port_vec !== {1'b0, 1'b1, 32'h0, 32'h0, 4'h0}) begin
            errors++; $display("FAIL reset_port: got %h expected %h", port_vec, {1'b0, 1'b1, 32'h0, 32'h0, 4'h0});
        end
        checks++;
        if ({done_vec, busy, stall_pc, ld_rdata} !== {5'b0, 32'h0}) begin
            errors++; $display("FAIL reset_status: got %h expected 0", {done_vec, busy, stall_pc, ld_rdata});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_store();
        st_req = 1; st_addr = 32'h100; st_wdata = 32'hDEADBEEF; st_be = 4'b1111;
        #1;
        checks++;
        if (stall_pc !== 1'b1) begin errors++; $display("FAIL store_stall_comb: got %b expected 1", stall_pc); end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (port_vec !== {1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 4'hF}) begin
                errors++; $display("FAIL store_port_%0d: got %h expected %h", i, port_vec, {1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 4'hF});
            end
            if (i == 1) mem_ack = 1;
        end
        tick();
        checks++;
        if ({done_vec, mem_req} !== 4'b1000) begin
            errors++; $display("FAIL store_done: got %b expected 1000", {done_vec, mem_req});
        end
        st_req = 0; mem_ack = 0;
        tick();
        checks++;
        if ({done_vec, busy, stall_pc} !== 5'b0) begin
            errors++; $display("FAIL store_idle: got %b expected 00000", {done_vec, busy, stall_pc});
        end
    endtask

    task automatic test_single_load();
        ld_req = 1; ld_addr = 32'h204; ld_be = 4'b0011;
        tick();
        checks++;
        if (port_vec !== {1'b1, 1'b1, 32'h204, 32'h0, 4'h3}) begin
            errors++; $display("FAIL load_port: got %h expected %h", port_vec, {1'b1, 1'b1, 32'h204, 32'h0, 4'h3});
        end
        mem_ack = 1; mem_rdata = 32'h1234ABCD;
        tick();
        checks++;
        if ({done_vec, ld_rdata} !== {3'b010, 32'h1234ABCD}) begin
            errors++; $display("FAIL load_done: got %h expected %h", {done_vec, ld_rdata}, {3'b010, 32'h1234ABCD});
        end
        ld_req = 0; mem_ack = 0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [69:0] exp_port;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        st_addr = 32'h10; st_wdata = 32'hAAAA5555; st_be = 4'hF;
        ld_addr = 32'h20; ld_be = 4'h5;
        st_req = 1; ld_req = 1; mem_ack = 1; mem_rdata = 32'h1234ABCD;
        for (int i = 0; i < 4; i++) begin
            exp_port = (i % 2 == 1) ? {1'b1, 1'b1, 32'h20, 32'h0, 4'h5}
                                    : {1'b1, 1'b0, 32'h10, 32'hAAAA5555, 4'hF};
            tick();
            checks++;
            if (port_vec !== exp_port) begin
                errors++; $display("FAIL tie_grant_%0d: got %h expected %h", i, port_vec, exp_port);
            end
            tick();
            checks++;
            if ({st_done, ld_done} !== ((i % 2 == 1) ? 2'b01 : 2'b10)) begin
                errors++; $display("FAIL tie_done_%0d: got %b expected %b", i, {st_done, ld_done}, (i % 2 == 1) ? 2'b01 : 2'b10);
            end
            if (i == 3) begin st_req = 0; ld_req = 0; mem_ack = 0; end
            tick();
            checks++;
            if (busy !== 1'b0) begin errors++; $display("FAIL tie_idle_%0d: got %b expected 0", i, busy); end
        end
    endtask

    task automatic test_timeout();
        ld_req = 1; ld_addr = 32'h300; ld_be = 4'hF;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if ({mem_req, done_vec} !== 4'b1000) begin
            errors++; $display("FAIL tmo_busy4: got %b expected 1000", {mem_req, done_vec});
        end
        tick();
        checks++;
        if ({done_vec, mem_req, ld_rdata} !== {3'b011, 1'b0, 32'h0}) begin
            errors++; $display("FAIL tmo_abort: got %h expected %h", {done_vec, mem_req, ld_rdata}, {3'b011, 1'b0, 32'h0});
        end
        ld_req = 0;
        tick();
        checks++;
        if ({busy, done_vec} !== 4'b0) begin errors++; $display("FAIL tmo_idle: got %b expected 0000", {busy, done_vec}); end
        ld_req = 1;
        for (int i = 0; i < 4; i++) tick();
        mem_ack = 1; mem_rdata = 32'hCAFEF00D;
        tick();
        checks++;
        if ({done_vec, ld_rdata} !== {3'b010, 32'hCAFEF00D}) begin
            errors++; $display("FAIL tmo_ack_wins: got %h expected %h", {done_vec, ld_rdata}, {3'b010, 32'hCAFEF00D});
        end
        ld_req = 0; mem_ack = 0;
        tick();
    endtask

    task automatic test_reset_mid_access();
        st_req = 1; st_addr = 32'h400; st_wdata = 32'h55; st_be = 4'h1;
        tick();
        checks++;
        if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_mid_busy: got %b expected 1", mem_req); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({port_vec, busy, ld_rdata} !== {1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0}) begin
            errors++; $display("FAIL rst_mid_async: got %h expected %h", {port_vec, busy, ld_rdata}, {1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0});
        end
        st_req = 0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({busy, done_vec} !== 4'b0) begin
                errors++; $display("FAIL rst_mid_nodone_%0d: got %b expected 0000", i, {busy, done_vec});
            end
        end
    endtask

    task automatic test_spurious_ack();
        mem_ack = 1;
        tick();
        checks++;
        if ({busy, mem_req, stall_pc} !== 3'b0) begin
            errors++; $display("FAIL spur_idle: got %b expected 000", {busy, mem_req, stall_pc});
        end
        mem_ack = 0; st_req = 1; st_addr = 32'h500; st_wdata = 32'h77; st_be = 4'h2;
        #1;
        checks++;
        if ({stall_pc, busy} !== 2'b10) begin errors++; $display("FAIL spur_stall_rise: got %b expected 10", {stall_pc, busy}); end
        tick();
        mem_ack = 1;
        tick();
        st_req = 0;
        #1;
        checks++;
        if ({st_done, stall_pc} !== 2'b11) begin errors++; $display("FAIL spur_done: got %b expected 11", {st_done, stall_pc}); end
        tick();
        checks++;
        if ({busy, mem_req, stall_pc, st_done} !== 4'b0) begin
            errors++; $display("FAIL spur_after_done: got %b expected 0000", {busy, mem_req, stall_pc, st_done});
        end
        mem_ack = 0;
    endtask

    initial begin
        test_reset();
        test_single_store();
        test_single_load();
        test_back_to_back();
        test_timeout();
        test_reset_mid_access();
        test_spurious_ack();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
